// File: rtl/dmi_pkg.sv
// Shared Debug Module Interface definitions: bus widths, op and response
// encodings, the request record and the arbiter controller states.
package dmi_pkg;

  localparam int DMI_ADDR_W = 7;
  localparam int DMI_DATA_W = 32;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2
  } dmi_op_e;

  localparam logic [1:0] DMI_RESP_SUCCESS = 2'd0;
  localparam logic [1:0] DMI_RESP_FAILED  = 2'd2;
  localparam logic [1:0] DMI_RESP_BUSY    = 2'd3;

  // op kept as raw bits so the reserved encoding 3 travels through untouched
  typedef struct packed {
    logic [DMI_ADDR_W-1:0] addr;
    logic [1:0]            op;
    logic [DMI_DATA_W-1:0] data;
  } dmi_req_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_RESP
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request searching upward
// from last+1, wrapping modulo N.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  int idx;

  // Scanning from the farthest candidate back to the nearest lets the
  // nearest asserted request overwrite any earlier pick.
  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no
    // path leaves a value held and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    idx       = 0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/dmi_arbiter.sv
// Shares one DMI slave port between N_REQ debug transports: round-robin grant,
// one outstanding transaction, response steered back to the owner.
module dmi_arbiter
  import dmi_pkg::*;
#(
  parameter  int N_REQ  = 2,
  parameter  int ADDR_W = DMI_ADDR_W,
  localparam int IW     = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             in_req_valid,
  output logic [N_REQ-1:0]             in_req_ready,
  input  logic [N_REQ*ADDR_W-1:0]      in_req_addr,
  input  logic [N_REQ*2-1:0]           in_req_op,
  input  logic [N_REQ*DMI_DATA_W-1:0]  in_req_data,
  output logic [N_REQ-1:0]             in_resp_valid,
  input  logic [N_REQ-1:0]             in_resp_ready,
  output logic [N_REQ*2-1:0]           in_resp_resp,
  output logic [N_REQ*DMI_DATA_W-1:0]  in_resp_data,
  output logic                         out_req_valid,
  output logic [ADDR_W-1:0]            out_req_addr,
  output logic [1:0]                   out_req_op,
  output logic [DMI_DATA_W-1:0]        out_req_data,
  input  logic                         out_req_ready,
  input  logic                         out_resp_valid,
  input  logic [1:0]                   out_resp_resp,
  input  logic [DMI_DATA_W-1:0]        out_resp_data,
  output logic                         out_resp_ready,
  output logic [IW-1:0]                owner,
  output logic                         busy
);

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [1:0]            op;
    logic [DMI_DATA_W-1:0] data;
  } req_t;

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    last_q, owner_q;
  req_t             req_q, req_sel;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    grant_idx;
  logic             capture, resp_done;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req       (in_req_valid),
    .last      (last_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_sel = '{
    addr: in_req_addr[grant_idx*ADDR_W +: ADDR_W],
    op:   in_req_op[grant_idx*2 +: 2],
    data: in_req_data[grant_idx*DMI_DATA_W +: DMI_DATA_W]
  };

  // Handshake outputs are held low while reset is asserted so no requester
  // or downstream slave sees an accept that the reset is about to discard.
  always_comb begin
    state_d        = state_q;
    in_req_ready   = '0;
    in_resp_valid  = '0;
    out_req_valid  = 1'b0;
    out_resp_ready = 1'b0;
    capture        = 1'b0;
    resp_done      = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ARB_IDLE: begin
          in_req_ready = grant;
          if (|grant) begin
            capture = 1'b1;
            state_d = ARB_REQ;
          end
        end
        ARB_REQ: begin
          out_req_valid = 1'b1;
          if (out_req_ready) state_d = ARB_RESP;
        end
        ARB_RESP: begin
          in_resp_valid[owner_q] = out_resp_valid;
          out_resp_ready         = in_resp_ready[owner_q];
          if (out_resp_valid && in_resp_ready[owner_q]) begin
            resp_done = 1'b1;
            state_d   = ARB_IDLE;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    if (reset) begin
      state_q <= ARB_IDLE;
      last_q  <= IW'(N_REQ - 1);
      owner_q <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        owner_q <= grant_idx;
        req_q   <= req_sel;
      end
      if (resp_done) last_q <= owner_q;
    end
  end

  assign out_req_addr = req_q.addr;
  assign out_req_op   = req_q.op;
  assign out_req_data = req_q.data;
  assign in_resp_resp = {N_REQ{out_resp_resp}};
  assign in_resp_data = {N_REQ{out_resp_data}};
  assign owner        = owner_q;
  assign busy         = (state_q != ARB_IDLE);

endmodule
